button_debounce: RTL and testbench

// - Debounces N_BTN raw push-buttons using the divided debounce clock as a sample strobe.
// - All logic runs on the system clock. de_clk is treated as data, synchronised, and its

---
 rtl/button_debounce_pkg.sv | 28 ++
 rtl/button_debounce_if.sv | 44 ++++
 rtl/button_debounce_channel.sv | 156 +++++++++++++++
 rtl/button_debounce.sv | 80 ++++++++
 tb/tb_button_debounce.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/button_debounce_pkg.sv
`default_nettype none
// ============================================================================
// Module      : button_debounce_pkg
// Description : Channel state encoding and counter-width helpers for the
//               button debouncer.
// Revision    : 1.0
// ============================================================================
package button_debounce_pkg;

    typedef enum logic [1:0] {
        S_LOW  = 2'd0,
        S_RISE = 2'd1,
        S_HIGH = 2'd2,
        S_FALL = 2'd3
    } state_t;

    // Width of the agreeing-sample counter; it must be able to hold STABLE_SAMPLES
    function automatic int cnt_width(input int stable_samples);
        return $clog2(stable_samples + 1);
    endfunction

    // Width of the long-press counter; it saturates at HOLD_SAMPLES
    function automatic int hold_width(input int hold_samples);
        return $clog2(hold_samples + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/button_debounce_if.sv
`default_nettype none
// ============================================================================
// Module      : button_debounce_if
// Description : Raw button / strobe inputs and debounced outputs of the
//               button debouncer.
// Revision    : 1.0
// ============================================================================
interface button_debounce_if #(
    parameter int N_BTN = 5
);
    import button_debounce_pkg::*;

    logic             de_clk;
    logic [N_BTN-1:0] btn_in;
    logic             sample_tick;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;
    logic [N_BTN-1:0] btn_hold;

    // Debouncer side
    modport slave (
        input  de_clk,
        input  btn_in,
        output sample_tick,
        output btn_level,
        output btn_press,
        output btn_release,
        output btn_hold
    );

    // Stimulus / consumer side
    modport master (
        output de_clk,
        output btn_in,
        input  sample_tick,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  btn_hold
    );

endinterface
`default_nettype wire

// File: rtl/button_debounce_channel.sv
`default_nettype none
// ============================================================================
// Module      : debounce_channel
// Description : One debounced button: four-state acceptance FSM, agreeing-
//               sample and long-press counters, registered outputs.
// Revision    : 1.0
// ============================================================================
module debounce_channel
    import button_debounce_pkg::*;
#(
    parameter int STABLE_SAMPLES = 4,
    parameter int HOLD_SAMPLES   = 64
) (
    input  wire  clk,
    input  wire  clr_n,
    input  wire  tick,
    input  wire  sample,
    output logic level,
    output logic press,
    output logic release_pulse,
    output logic hold
);

    localparam int CNT_W  = cnt_width(STABLE_SAMPLES);
    localparam int HOLD_W = hold_width(HOLD_SAMPLES);

    localparam logic [CNT_W-1:0]  c_stable = CNT_W'(STABLE_SAMPLES);
    localparam logic [HOLD_W-1:0] c_hold   = HOLD_W'(HOLD_SAMPLES);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [CNT_W-1:0]    w_cnt_inc;
    logic [HOLD_W-1:0]   r_hold_cnt;
    logic [HOLD_W-1:0]   w_hold_cnt_nxt;
    logic                w_press_nxt;
    logic                w_release_nxt;
    logic                w_level_nxt;
    logic                w_hold_nxt;

    logic r_level;
    logic r_press;
    logic r_release;
    logic r_hold;

    assign w_cnt_inc = r_cnt + CNT_W'(1);

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_hold_cnt_nxt = r_hold_cnt;
        w_press_nxt    = 1'b0;
        w_release_nxt  = 1'b0;

        if (tick) begin
            case (r_state)
                S_LOW: begin
                    if (sample) begin
                        if (STABLE_SAMPLES == 1) begin
                            w_state_nxt    = S_HIGH;
                            w_cnt_nxt      = '0;
                            w_hold_cnt_nxt = '0;
                            w_press_nxt    = 1'b1;
                        end else begin
                            w_state_nxt = S_RISE;
                            w_cnt_nxt   = CNT_W'(1);
                        end
                    end
                end
                S_RISE: begin
                    if (sample) begin
                        if (w_cnt_inc == c_stable) begin
                            w_state_nxt    = S_HIGH;
                            w_cnt_nxt      = '0;
                            w_hold_cnt_nxt = '0;
                            w_press_nxt    = 1'b1;
                        end else begin
                            w_cnt_nxt = w_cnt_inc;
                        end
                    end else begin
                        // Bounce before acceptance is silently discarded
                        w_state_nxt = S_LOW;
                        w_cnt_nxt   = '0;
                    end
                end
                S_HIGH: begin
                    if (!sample) begin
                        if (STABLE_SAMPLES == 1) begin
                            w_state_nxt    = S_LOW;
                            w_cnt_nxt      = '0;
                            w_hold_cnt_nxt = '0;
                            w_release_nxt  = 1'b1;
                        end else begin
                            w_state_nxt = S_FALL;
                            w_cnt_nxt   = CNT_W'(1);
                        end
                    end else if (r_hold_cnt != c_hold) begin
                        w_hold_cnt_nxt = r_hold_cnt + HOLD_W'(1);
                    end
                end
                S_FALL: begin
                    if (!sample) begin
                        if (w_cnt_inc == c_stable) begin
                            w_state_nxt    = S_LOW;
                            w_cnt_nxt      = '0;
                            w_hold_cnt_nxt = '0;
                            w_release_nxt  = 1'b1;
                        end else begin
                            w_cnt_nxt = w_cnt_inc;
                        end
                    end else begin
                        // Glitch low while held: long-press progress is kept
                        w_state_nxt = S_HIGH;
                        w_cnt_nxt   = '0;
                    end
                end
                default: begin
                    w_state_nxt    = S_LOW;
                    w_cnt_nxt      = '0;
                    w_hold_cnt_nxt = '0;
                end
            endcase
        end
    end

    assign w_level_nxt = (w_state_nxt == S_HIGH) || (w_state_nxt == S_FALL);
    assign w_hold_nxt  = w_level_nxt && (w_hold_cnt_nxt == c_hold);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state    <= S_LOW;
            r_cnt      <= '0;
            r_hold_cnt <= '0;
            r_level    <= 1'b0;
            r_press    <= 1'b0;
            r_release  <= 1'b0;
            r_hold     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
            r_level    <= w_level_nxt;
            r_press    <= w_press_nxt;
            r_release  <= w_release_nxt;
            r_hold     <= w_hold_nxt;
        end
    end

    assign level         = r_level;
    assign press         = r_press;
    assign release_pulse = r_release;
    assign hold          = r_hold;

endmodule
`default_nettype wire

// File: rtl/button_debounce.sv
`default_nettype none
// ============================================================================
// Module      : button_debounce
// Description : Synchronises the divided debounce clock into a sample strobe
//               and the raw buttons, then debounces each button independently.
// Revision    : 1.0
// ============================================================================
module button_debounce
    import button_debounce_pkg::*;
#(
    parameter int N_BTN          = 5,
    parameter int STABLE_SAMPLES = 4,
    parameter int HOLD_SAMPLES   = 64
) (
    input wire              clk,
    input wire              clr_n,
    button_debounce_if.slave bus
);

    logic             r_de_meta;
    logic             r_de_sync;
    logic             r_de_prev;
    logic             r_tick;
    logic [N_BTN-1:0] r_btn_meta;
    logic [N_BTN-1:0] r_btn_sync;

    logic [N_BTN-1:0] w_level;
    logic [N_BTN-1:0] w_press;
    logic [N_BTN-1:0] w_release;
    logic [N_BTN-1:0] w_hold;

    // de_clk is only ever data here; its synced rising edge becomes the strobe
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_de_meta <= 1'b0;
            r_de_sync <= 1'b0;
            r_de_prev <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            r_de_meta <= bus.de_clk;
            r_de_sync <= r_de_meta;
            r_de_prev <= r_de_sync;
            r_tick    <= r_de_sync & ~r_de_prev;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_btn_meta <= '0;
            r_btn_sync <= '0;
        end else begin
            r_btn_meta <= bus.btn_in;
            r_btn_sync <= r_btn_meta;
        end
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        debounce_channel #(
            .STABLE_SAMPLES (STABLE_SAMPLES),
            .HOLD_SAMPLES   (HOLD_SAMPLES)
        ) u_chan (
            .clk           (clk),
            .clr_n         (clr_n),
            .tick          (r_tick),
            .sample        (r_btn_sync[i]),
            .level         (w_level[i]),
            .press         (w_press[i]),
            .release_pulse (w_release[i]),
            .hold          (w_hold[i])
        );
    end

    assign bus.sample_tick = r_tick;
    assign bus.btn_level   = w_level;
    assign bus.btn_press   = w_press;
    assign bus.btn_release = w_release;
    assign bus.btn_hold    = w_hold;

endmodule
`default_nettype wire

// File: tb/tb_button_debounce.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_debounce
// Description : Randomised and directed stimulus for button_debounce, checked
//               by a queue scoreboard against a per-sample reference model.
// Revision    : 1.0
// ============================================================================
module tb_button_debounce;

    localparam int NB     = 5;
    localparam int STABLE = 4;
    localparam int HOLD   = 64;

    typedef struct {
        logic [NB-1:0] level;
        logic [NB-1:0] press;
        logic [NB-1:0] rel;
        logic [NB-1:0] hold;
    } exp_t;

    logic clk;
    logic clr_n;

    button_debounce_if #(.N_BTN(NB)) bus ();

    button_debounce #(
        .N_BTN          (NB),
        .STABLE_SAMPLES (STABLE),
        .HOLD_SAMPLES   (HOLD)
    ) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    exp_t          sb_q[$];
    int            errors = 0;
    int            checks = 0;
    int            pushed = 0;
    int            ticks_seen = 0;

    // Reference model: accepted level, length of the current disagreeing run,
    // and number of high samples counted since acceptance.
    logic [NB-1:0] m_level;
    int            m_run  [NB];
    int            m_held [NB];

    task automatic model_reset();
        m_level = '0;
        for (int i = 0; i < NB; i++) begin
            m_run[i]  = 0;
            m_held[i] = 0;
        end
    endtask

    task automatic model_tick(input logic [NB-1:0] b);
        exp_t e;
        e.press = '0;
        e.rel   = '0;
        for (int i = 0; i < NB; i++) begin
            if (b[i] == m_level[i]) begin
                if (m_level[i] && m_run[i] == 0 && m_held[i] < HOLD)
                    m_held[i]++;
                m_run[i] = 0;
            end else begin
                m_run[i]++;
                if (m_run[i] == STABLE) begin
                    m_level[i] = b[i];
                    m_run[i]   = 0;
                    m_held[i]  = 0;
                    if (b[i]) e.press[i] = 1'b1;
                    else      e.rel[i]   = 1'b1;
                end
            end
        end
        e.level = m_level;
        for (int i = 0; i < NB; i++)
            e.hold[i] = m_level[i] && (m_held[i] == HOLD);
        sb_q.push_back(e);
        pushed++;
    endtask

    // One de_clk period: 6 clk low (new button value applied), 6 clk high.
    // With glitch set, the buttons change on the very cycle the tick is seen.
    task automatic step(input logic [NB-1:0] b, input bit in_reset, input bit glitch);
        @(negedge clk);
        clr_n      = !in_reset;
        if (in_reset) model_reset();
        bus.de_clk = 1'b0;
        bus.btn_in = b;
        repeat (6) @(negedge clk);
        bus.de_clk = 1'b1;
        if (clr_n) model_tick(b);
        if (glitch) begin
            repeat (3) @(negedge clk);
            bus.btn_in = NB'($urandom);
            repeat (2) @(negedge clk);
        end else begin
            repeat (5) @(negedge clk);
        end
    endtask

    task automatic steps(input logic [NB-1:0] b, input int n);
        for (int k = 0; k < n; k++) step(b, 1'b0, 1'b0);
    endtask

    // Monitor: the cycle after every tick the DUT presents new outputs
    initial begin : monitor
        logic [NB-1:0] cur_level;
        logic [NB-1:0] cur_hold;
        bit            prev_tick;
        exp_t          e;
        cur_level = '0;
        cur_hold  = '0;
        prev_tick = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (!clr_n) begin
                checks++;
                if (bus.sample_tick !== 1'b0 || bus.btn_level !== '0 || bus.btn_press !== '0 ||
                    bus.btn_release !== '0 || bus.btn_hold !== '0) begin
                    errors++;
                    $display("FAIL reset_outputs: got tick=%b level=%b press=%b rel=%b hold=%b, expected all zero",
                             bus.sample_tick, bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_hold);
                end
                cur_level = '0;
                cur_hold  = '0;
                prev_tick = 1'b0;
            end else begin
                if (prev_tick) begin
                    ticks_seen++;
                    checks++;
                    if (sb_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_tick: got a sample tick, expected none (scoreboard empty)");
                    end else begin
                        e = sb_q.pop_front();
                        if (bus.btn_level !== e.level || bus.btn_press !== e.press ||
                            bus.btn_release !== e.rel || bus.btn_hold !== e.hold) begin
                            errors++;
                            $display("FAIL tick_outputs @%0t: got level=%b press=%b rel=%b hold=%b, expected level=%b press=%b rel=%b hold=%b",
                                     $time, bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_hold,
                                     e.level, e.press, e.rel, e.hold);
                        end
                        cur_level = e.level;
                        cur_hold  = e.hold;
                    end
                end else begin
                    checks++;
                    if (bus.btn_press !== '0 || bus.btn_release !== '0 ||
                        bus.btn_level !== cur_level || bus.btn_hold !== cur_hold) begin
                        errors++;
                        $display("FAIL idle_outputs @%0t: got level=%b press=%b rel=%b hold=%b, expected level=%b press=0 rel=0 hold=%b",
                                 $time, bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_hold,
                                 cur_level, cur_hold);
                    end
                end
                prev_tick = bus.sample_tick;
            end
        end
    end

    initial begin : stimulus
        logic [NB-1:0] b;
        int            wait_cnt;
        clr_n      = 1'b0;
        bus.de_clk = 1'b0;
        bus.btn_in = '1;
        model_reset();

        // Held in reset with all buttons pressed and de_clk toggling
        for (int k = 0; k < 3; k++) step(5'h1F, 1'b1, 1'b0);
        steps(5'h1F, 6);
        steps(5'h00, 6);

        // Clean press on button 0
        steps(5'h01, 10);
        steps(5'h00, 5);

        // Bounce into and out of a press on button 1
        begin
            logic [8:0] rise_pat;
            logic [5:0] fall_pat;
            rise_pat = 9'b1_1110_1101;
            fall_pat = 6'b00_0010;
            for (int k = 0; k < 9; k++) step(rise_pat[k] ? 5'h02 : 5'h00, 1'b0, 1'b0);
            steps(5'h02, 2);
            for (int k = 0; k < 6; k++) step(fall_pat[k] ? 5'h02 : 5'h00, 1'b0, 1'b0);
            steps(5'h00, 2);
        end

        // Long press on button 2, including a short glitch low during the hold
        steps(5'h04, 30);
        steps(5'h00, 2);
        steps(5'h04, 40);
        steps(5'h00, 5);

        // Simultaneous press on 3 and 4, reset mid-qualification, then requalify
        steps(5'h18, 2);
        for (int k = 0; k < 2; k++) step(5'h18, 1'b1, 1'b0);
        steps(5'h18, 6);
        for (int k = 0; k < 2; k++) step(5'h18, 1'b1, 1'b0);
        steps(5'h18, 6);
        steps(5'h00, 5);

        // Random bouncing with changes landing on the tick cycle
        b = '0;
        for (int k = 0; k < 100; k++) begin
            for (int i = 0; i < NB; i++)
                if ($urandom_range(3) == 0) b[i] = ~b[i];
            step(b, 1'b0, 1'($urandom_range(1)));
        end
        steps(5'h00, 6);

        wait_cnt = 0;
        while (sb_q.size() != 0 && wait_cnt < 50) begin
            @(negedge clk);
            wait_cnt++;
        end
        repeat (4) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
        end
        checks++;
        if (ticks_seen != pushed) begin
            errors++;
            $display("FAIL tick_count: got %0d ticks, expected %0d", ticks_seen, pushed);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
